wb_arb2: RTL and testbench

Two-master round-robin arbiter for the 16-bit Wishbone register bus. It shares a single slave port, such as an input-register block or a control-register block, between two bus masters, for example the VME/USB bridge and the on-chip sequencer. It holds the grant for a whole bus cycle (while `cyc` stays high), so block reads are not interleaved. An optional watchdog terminates cycles the slave never acknowledges.

---
 rtl/wb_arb2.sv | 135 +++++++++++++
 tb/tb_wb_arb2.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter; grant held for a whole cyc.
// Optional slave watchdog enabled by defining WB_ARB_TMO_EN.
//   state | meaning
//   IDLE  | no owner, slave outputs forced to 0, arbitrate on m_cyc
//   BUSY  | grant owner, slave port muxed from the granted master
module wb_arb2 #(
  parameter int ADRBITS = 1,
  parameter int TMOBITS = 4
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [1:0]             m_cyc,
  input  logic [1:0]             m_stb,
  input  logic [1:0]             m_we,
  input  logic [2*ADRBITS-1:0]   m_adr,
  input  logic [31:0]            m_dat_w,
  output logic [15:0]            m_dat_r,
  output logic [1:0]             m_ack,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [ADRBITS-1:0]     s_adr,
  output logic [15:0]            s_dat_w,
  input  logic [15:0]            s_dat_r,
  input  logic                   s_ack,
  output logic [1:0]             grant,
  output logic                   arb_tmo
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic         last_q, last_d;

  logic               busy;
  logic               sel;
  logic               cyc_g, stb_g, we_g;
  logic [ADRBITS-1:0] adr_g;
  logic [15:0]        dat_g;
  logic               ack_g;
  logic               tmo_hit;

  assign busy = (state_q == BUSY);
  assign sel  = grant_q[1];

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m_cyc != 2'b00) begin
          state_d = BUSY;
          if (m_cyc == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
          else                grant_d = m_cyc;
        end
      end
      BUSY: begin
        // Every handover goes through IDLE, giving one dead cycle between owners.
        if (!(sel ? m_cyc[1] : m_cyc[0])) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = sel;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign cyc_g = sel ? m_cyc[1] : m_cyc[0];
  assign stb_g = sel ? m_stb[1] : m_stb[0];
  assign we_g  = sel ? m_we[1]  : m_we[0];
  assign adr_g = sel ? m_adr[2*ADRBITS-1:ADRBITS] : m_adr[ADRBITS-1:0];
  assign dat_g = sel ? m_dat_w[31:16] : m_dat_w[15:0];

  assign s_cyc   = busy & cyc_g;
  assign s_stb   = busy & stb_g;
  assign s_we    = busy & we_g;
  assign s_adr   = busy ? adr_g : '0;
  assign s_dat_w = busy ? dat_g : 16'h0000;

  assign ack_g   = busy & stb_g & (s_ack | tmo_hit);
  assign m_ack   = {ack_g & sel, ack_g & ~sel};
  assign m_dat_r = !busy  ? 16'h0000 :
                   tmo_hit ? 16'hFFFF : s_dat_r;
  assign grant   = grant_q;

`ifdef WB_ARB_TMO_EN
  localparam logic [TMOBITS-1:0] TMO_MAX = '1;

  logic [TMOBITS-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               arb_tmo_q, arb_tmo_d;

  assign tmo_hit = busy & stb_g & ~s_ack & (tmo_cnt_q == TMO_MAX);

  always_comb begin
    tmo_cnt_d = '0;
    arb_tmo_d = arb_tmo_q | tmo_hit;
    if (busy && stb_g && !s_ack && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tmo_cnt_q <= '0;
      arb_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      arb_tmo_q <= arb_tmo_d;
    end
  end

  assign arb_tmo = arb_tmo_q;
`else
  assign tmo_hit = 1'b0;
  // Always 0; references TMOBITS so the unused parameter stays visible to lint.
  assign arb_tmo = (TMOBITS < 0);
`endif

endmodule

// File: tb/tb_wb_arb2.sv
// Randomized scoreboard bench for wb_arb2 with a registered-ack slave model.
module tb_wb_arb2;

  localparam int AB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
  logic [2*AB-1:0] m_adr = '0;
  logic [31:0]     m_dat_w = '0;
  logic [15:0]     m_dat_r;
  logic [1:0]      m_ack;
  logic            s_cyc, s_stb, s_we;
  logic [AB-1:0]   s_adr;
  logic [15:0]     s_dat_w;
  logic [15:0]     s_dat_r = '0;
  logic            s_ack = 1'b0;
  logic [1:0]      grant;
  logic            arb_tmo;

  wb_arb2 #(.ADRBITS(AB), .TMOBITS(4)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant), .arb_tmo(arb_tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [15:0] rd;
  } exp_t;

  exp_t         q0[$], q1[$];
  logic [17:0]  wlog[$];
  logic [15:0]  rom[4];
  logic         slave_mute = 1'b0;
  int           errors = 0, checks = 0;
  int           own = -1, last = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Slave: ack and read data registered one cycle after cyc&stb, repeated while stb held.
  always @(posedge clk) begin
    s_ack <= s_cyc & s_stb & ~slave_mute;
    if (s_cyc && s_stb) s_dat_r <= rom[s_adr];
    if (s_cyc && s_stb && s_we && !s_ack && !slave_mute) wlog.push_back({s_adr, s_dat_w});
  end

  // Reference arbitration: owner / last-served per round-robin rules.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        own = -1; last = 1;
      end else if (own < 0) begin
        if (m_cyc == 2'b11)  own = (last == 0) ? 1 : 0;
        else if (m_cyc[0])   own = 0;
        else if (m_cyc[1])   own = 1;
      end else if (!m_cyc[own]) begin
        last = own; own = -1;
      end
    end
  end

  task automatic score(input int i);
    exp_t e;
    logic [17:0] w;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_ack m%0d: ack seen, required none outstanding", i);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      if (!e.we) chk("read_data", m_dat_r, e.rd);
      else if (wlog.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_missing m%0d: slave saw no write, required adr=%h dat=%h", i, e.adr, e.dat);
      end else begin
        w = wlog.pop_front();
        chk("write_routing", w, {e.adr, e.dat});
      end
    end
  endtask

  // Monitor: compares outputs with the reference each cycle, pops scoreboard on acks.
  initial begin
    logic [1:0] eg;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        eg = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        chk("grant", grant, eg);
        if (own < 0) begin
          chk("idle_outputs", {m_ack, s_cyc, s_stb, s_we, s_adr, s_dat_w, m_dat_r}, '0);
        end else begin
          chk("route", {s_cyc, s_stb, s_we, s_adr, s_dat_w},
              {m_cyc[own], m_stb[own], m_we[own], m_adr[own*AB +: AB], m_dat_w[own*16 +: 16]});
          chk("ack_other_master", m_ack[1-own], 1'b0);
          if (m_ack[own]) score(own);
        end
      end
    end
  end

  task automatic master_run(input int i, input int ntrans);
    exp_t e;
    int nx, budget;
    for (int t = 0; t < ntrans; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 m_cyc[i] = 1'b1;
      nx = $urandom_range(1, 3);
      for (int x = 0; x < nx; x++) begin
        if (x > 0) begin @(posedge clk); #1; end
        e.we  = 1'($urandom_range(0, 1));
        e.adr = 2'($urandom_range(0, 3));
        e.dat = 16'($urandom);
        e.rd  = rom[e.adr];
        m_we[i] = e.we;
        m_adr[i*AB +: AB] = e.adr;
        m_dat_w[i*16 +: 16] = e.dat;
        m_stb[i] = 1'b1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        budget = 0;
        do begin @(negedge clk); budget++; end while (!m_ack[i] && budget < 200);
        checks++;
        if (!m_ack[i]) begin
          errors++;
          $display("FAIL ack_wait m%0d: no m_ack after %0d cycles, required within 200", i, budget);
        end
        @(posedge clk); #1 m_stb[i] = 1'b0;
      end
      m_cyc[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: still running, required to finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, acks;
    bit got;
    for (int k = 0; k < 4; k++) rom[k] = 16'($urandom);

    // Requests held during reset must not be granted.
    m_cyc = 2'b11; m_stb = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_grant", grant, 2'b00);
    chk("reset_outputs", {m_ack, s_cyc, s_stb, s_we, s_adr, s_dat_w, m_dat_r, arb_tmo}, '0);
    m_cyc = 2'b00; m_stb = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie from reset: master 0 first, master 1 one cycle after master 0 is seen released.
    @(posedge clk); #1 m_cyc = 2'b11;
    @(posedge clk); @(negedge clk);
    chk("tie_first_m0", grant, 2'b01);
    @(posedge clk); #1 m_cyc[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("tie_idle_gap", grant, 2'b00);
    @(negedge clk);
    chk("tie_then_m1", grant, 2'b10);
    @(posedge clk); #1 m_cyc = 2'b00;

    fork
      master_run(0, 20);
      master_run(1, 20);
    join
    repeat (3) @(posedge clk);
    chk("queues_drained", q0.size() + q1.size() + wlog.size(), 0);

    // Hung slave.
    slave_mute = 1'b1;
    @(posedge clk); #1 m_cyc[0] = 1'b1;
    @(posedge clk); #1 m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[AB-1:0] = '0;
`ifdef WB_ARB_TMO_EN
    q0.push_back('{we: 1'b0, adr: 2'd0, dat: 16'h0, rd: 16'hFFFF});
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (m_ack[0]) got = 1;
      else begin @(posedge clk); n++; end
    end
    chk("tmo_latency", n, 15);
    @(posedge clk); #1 m_stb[0] = 1'b0;
    @(negedge clk);
    chk("arb_tmo_set", arb_tmo, 1'b1);
`else
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_ack[0]) acks++;
    end
    chk("hung_no_ack", acks, 0);
    chk("arb_tmo_off", arb_tmo, 1'b0);
    @(posedge clk); #1 m_stb[0] = 1'b0;
`endif
    @(posedge clk); #1 m_cyc[0] = 1'b0; slave_mute = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of master 1's acked read.
    #1 m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[2*AB-1:AB] = 2'd2;
    q1.push_back('{we: 1'b0, adr: 2'd2, dat: 16'h0, rd: rom[2]});
    n = 0;
    do begin @(negedge clk); n++; end while (!m_ack[1] && n < 20);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", grant, 2'b00);
    chk("rst_mid_s_cyc", s_cyc, 1'b0);
    chk("rst_mid_m_ack", m_ack, 2'b00);
    chk("rst_mid_arb_tmo", arb_tmo, 1'b0);
    m_cyc = 2'b00; m_stb = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("final_drained", q0.size() + q1.size() + wlog.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
